alarm_controller: RTL and testbench
===================================

# alarm_controller

Anti-theft controller that sequences the shared `timer` countdown block. It watches the ignition and door sensors and holds four programmable 4-bit delay parameters. It launches the timer with the correct `value` for each phase and drives the siren and status LED. It sits between the synchronized/debounced sensor inputs and the `timer` instance; the timer's `expired` output feeds back here.

## Interface
- `T_ARM_DELAY_DEF`, 4'd6: default seconds from driver-door close to ARMED.
- `T_DRIVER_DEF`, 4'd8: default entry countdown, driver door.
- `T_PASSENGER_DEF`, 4'd15: default entry countdown, passenger door.
- `T_ALARM_ON_DEF`, 4'd10: default siren duration after all doors close.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ignition` in 1: level, ignition switch on.
- `driver_door` in 1: level, 1 = open.
- `passenger_door` in 1: level, 1 = open.
- `reprogram` in 1: one-cycle pulse, write a parameter.
- `time_param_sel` in 2: parameter index. 0 = arm delay, 1 = driver, 2 = passenger, 3 = alarm-on.
- `time_value` in 4: value written on `reprogram`.
- `one_hz_enable` in 1: one-cycle tick per second, used for LED blink.
- `expired` in 1: from `timer`.
- `start_timer` out 1: one-cycle pulse to `timer`.
- `value` out 4: countdown length to `timer`; valid when `start_timer` is high; held until the next start.
- `siren` out 1: alarm output.
- `status_led` out 1: indicator.
- `fsm_state` out 3: current state, for debug display.

## Operation
- **Parameter file:** 4×4-bit registers, loaded with the defaults on reset. `reprogram` writes `time_value` into `param[time_param_sel]` and forces the FSM to ARMED with no timer start. Value 0 is stored verbatim.
- **Timer launch:** every `start_timer` pulse is accompanied by a `value` chosen from the parameter file.
- **States** (`fsm_state` encoding in brackets):
  - ARMED [0]: reset state.
    - `ignition` → DISARMED.
    - Else `driver_door` → TRIGGERED, start with `param[1]`.
    - Else `passenger_door` → TRIGGERED, start with `param[2]`.
    - Driver wins if both doors open in the same cycle.
  - TRIGGERED [1]:
    - `ignition` → DISARMED.
    - `expired` → SOUND, start with `param[3]`.
  - SOUND [2]: `siren` = 1.
    - `ignition` → DISARMED.
    - `expired` with both doors closed → ARMED.
    - `expired` with any door open → stay in SOUND and restart with `param[3]`.
  - DISARMED [3]:
    - `!ignition` → WAIT_OPEN.
  - WAIT_OPEN [4]:
    - `ignition` → DISARMED.
    - `driver_door` → WAIT_CLOSE.
  - WAIT_CLOSE [5]:
    - `ignition` → DISARMED.
    - Both doors closed → ARM_DELAY, start with `param[0]`.
  - ARM_DELAY [6]:
    - `ignition` → DISARMED.
    - Any door open → WAIT_CLOSE.
    - `expired` → ARMED.
- **Priority:** `reprogram` > `ignition` > `expired` / door conditions.
- **`status_led`:**
  - ARMED: toggles on each `one_hz_enable`, giving a 2 s period; forced to 0 on entry to ARMED.
  - TRIGGERED and SOUND: 1.
  - All other states: 0.

## Timing
- All outputs are registered.
- **Reset values:** `start_timer` = 0, `value` = 0, `siren` = 0, `status_led` = 0, `fsm_state` = 0 (ARMED), parameters = defaults.
- **Transition latency:** a transition caused by inputs sampled at edge N appears at edge N. On that same edge, `fsm_state` updates and `start_timer`/`value` are driven, so the timer sees the start pulse 1 cycle after the triggering input is sampled.
- **`start_timer` width:** exactly one cycle, never asserted on two consecutive cycles.
- **Stale-expiry rule:** `expired` is ignored
  - in the cycle `start_timer` is high and the following cycle, so a stale expiry from the previous run is discarded;
  - in states that do not use the timer (ARMED, DISARMED, WAIT_OPEN, WAIT_CLOSE).
- **`siren`:** combinationally equivalent to being in SOUND but registered, i.e. 1 exactly in cycles where `fsm_state` = 2.
- **`reset` mid-countdown:** the FSM returns to ARMED immediately (asynchronous) and no start is issued. The timer is reset by the same `reset` net.
- **`reprogram` while TRIGGERED or SOUND:** the siren drops on the next edge, the state becomes ARMED, and the new value takes effect on the next start.

## Test plan
- Reset, then `driver_door` = 1 for 1 cycle → TRIGGERED, `start_timer` pulse with `value` = 8. Then `expired` → SOUND, `siren` = 1, `value` = 10. Then `expired` with doors closed → ARMED, `siren` = 0.
- ARMED, both doors rise in the same cycle → `value` = 8 (driver priority). Separately, passenger only → `value` = 15.
- TRIGGERED, `ignition` = 1 before `expired` → DISARMED, no siren. Then:
  - ignition off → WAIT_OPEN;
  - driver open → WAIT_CLOSE;
  - close → ARM_DELAY with `value` = 6;
  - passenger opens mid-delay → WAIT_CLOSE;
  - close → new start with `value` = 6;
  - `expired` → ARMED.
- SOUND, `expired` while `passenger_door` = 1 → stays in SOUND, new start with `value` = 10.
- `reprogram` with sel = 1, `time_value` = 3 during SOUND → ARMED, `siren` = 0 next edge. Then driver open → `value` = 3, while other parameters keep their defaults. Then `reset` → driver open gives `value` = 8 again.
- `expired` asserted in the same cycle as `start_timer` → ignored, state unchanged.
- ARMED, 4 `one_hz_enable` ticks → `status_led` pattern 1, 0, 1, 0.

Source files
------------

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - anti-theft sequencer driving the shared countdown timer
module alarm_controller #(
  parameter logic [3:0] T_ARM_DELAY_DEF = 4'd6,
  parameter logic [3:0] T_DRIVER_DEF    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DEF = 4'd15,
  parameter logic [3:0] T_ALARM_ON_DEF  = 4'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ignition,
  input  logic       driver_door,
  input  logic       passenger_door,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       one_hz_enable,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] value,
  output logic       siren,
  output logic       status_led,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGERED  = 3'd1,
    SOUND      = 3'd2,
    DISARMED   = 3'd3,
    WAIT_OPEN  = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARM_DELAY  = 3'd6
  } state_t;

  state_t     state, state_next;
  logic [3:0] param [4];
  logic       start_d;
  logic       start_next;
  logic [3:0] value_next;
  logic       led_next;
  logic       any_door;
  logic       exp_ok;

  assign any_door  = driver_door | passenger_door;
  // An expiry seen while the start pulse is out or just after belongs to the previous run.
  assign exp_ok    = expired & ~start_timer & ~start_d;
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    start_next = 1'b0;
    value_next = value;
    if (reprogram) begin
      state_next = ARMED;
    end else if (ignition) begin
      state_next = DISARMED;
    end else begin
      case (state)
        ARMED: begin
          if (driver_door) begin
            state_next = TRIGGERED;
            start_next = 1'b1;
            value_next = param[1];
          end else if (passenger_door) begin
            state_next = TRIGGERED;
            start_next = 1'b1;
            value_next = param[2];
          end
        end
        TRIGGERED: begin
          if (exp_ok) begin
            state_next = SOUND;
            start_next = 1'b1;
            value_next = param[3];
          end
        end
        SOUND: begin
          if (exp_ok) begin
            if (any_door) begin
              start_next = 1'b1;
              value_next = param[3];
            end else begin
              state_next = ARMED;
            end
          end
        end
        DISARMED:  state_next = WAIT_OPEN;
        WAIT_OPEN: if (driver_door) state_next = WAIT_CLOSE;
        WAIT_CLOSE: begin
          if (!any_door) begin
            state_next = ARM_DELAY;
            start_next = 1'b1;
            value_next = param[0];
          end
        end
        ARM_DELAY: begin
          if (any_door)    state_next = WAIT_CLOSE;
          else if (exp_ok) state_next = ARMED;
        end
        default: state_next = ARMED;
      endcase
    end

    case (state_next)
      TRIGGERED, SOUND: led_next = 1'b1;
      ARMED:            led_next = (state == ARMED) ? (status_led ^ one_hz_enable) : 1'b0;
      default:          led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARMED;
      param[0]    <= T_ARM_DELAY_DEF;
      param[1]    <= T_DRIVER_DEF;
      param[2]    <= T_PASSENGER_DEF;
      param[3]    <= T_ALARM_ON_DEF;
      start_timer <= 1'b0;
      start_d     <= 1'b0;
      value       <= 4'd0;
      siren       <= 1'b0;
      status_led  <= 1'b0;
    end else begin
      state       <= state_next;
      if (reprogram) param[time_param_sel] <= time_value;
      start_timer <= start_next;
      start_d     <= start_timer;
      value       <= value_next;
      siren       <= (state_next == SOUND);
      status_led  <= led_next;
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - scoreboard bench for alarm_controller with a cycle-level reference model
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ignition = 1'b0, driver_door = 1'b0, passenger_door = 1'b0;
  logic       reprogram = 1'b0, one_hz_enable = 1'b0, expired = 1'b0;
  logic [1:0] time_param_sel = 2'd0;
  logic [3:0] time_value = 4'd0;
  logic       start_timer, siren, status_led;
  logic [3:0] value;
  logic [2:0] fsm_state;

  alarm_controller dut (
    .clk(clk), .reset(reset), .ignition(ignition), .driver_door(driver_door),
    .passenger_door(passenger_door), .reprogram(reprogram), .time_param_sel(time_param_sel),
    .time_value(time_value), .one_hz_enable(one_hz_enable), .expired(expired),
    .start_timer(start_timer), .value(value), .siren(siren), .status_led(status_led),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       start;
    logic [3:0] val;
    logic       sir;
    logic       led;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;

  // Reference model: state as a number, elapsed cycles since the last start pulse.
  int       m_st, m_age;
  bit [3:0] m_par [4];
  bit [3:0] m_val;
  bit       m_led;

  task automatic model_reset();
    m_st = 0; m_age = 3; m_val = 0; m_led = 0;
    m_par[0] = 6; m_par[1] = 8; m_par[2] = 15; m_par[3] = 10;
  endtask

  task automatic step(input bit rs, ign, dd, pd, rp, input bit [1:0] sel,
                      input bit [3:0] tv, input bit tk, ex);
    int   ns;
    bit   st_go, ok;
    exp_t e;
    @(negedge clk);
    reset = rs; ignition = ign; driver_door = dd; passenger_door = pd;
    reprogram = rp; time_param_sel = sel; time_value = tv; one_hz_enable = tk; expired = ex;
    if (rs) begin
      model_reset();
      e = '{3'd0, 1'b0, 4'd0, 1'b0, 1'b0};
      sb.push_back(e);
      return;
    end
    ns = m_st; st_go = 0;
    ok = ex && (m_age >= 2);
    if (rp) ns = 0;
    else if (ign) ns = 3;
    else begin
      case (m_st)
        0: if (dd) begin ns = 1; st_go = 1; m_val = m_par[1]; end
           else if (pd) begin ns = 1; st_go = 1; m_val = m_par[2]; end
        1: if (ok) begin ns = 2; st_go = 1; m_val = m_par[3]; end
        2: if (ok) begin
             if (dd || pd) begin st_go = 1; m_val = m_par[3]; end
             else ns = 0;
           end
        3: ns = 4;
        4: if (dd) ns = 5;
        5: if (!dd && !pd) begin ns = 6; st_go = 1; m_val = m_par[0]; end
        default: if (dd || pd) ns = 5; else if (ok) ns = 0;
      endcase
    end
    if (rp) m_par[sel] = tv;
    if (ns == 1 || ns == 2) m_led = 1;
    else if (ns == 0) m_led = (m_st == 0) ? (m_led ^ tk) : 1'b0;
    else m_led = 0;
    m_age = st_go ? 0 : ((m_age < 3) ? m_age + 1 : 3);
    m_st = ns;
    e.st = 3'(ns); e.start = st_go; e.val = m_val; e.sir = (ns == 2); e.led = m_led;
    sb.push_back(e);
  endtask

  task automatic s(input bit ign, dd, pd, ex, tk = 0);
    step(0, ign, dd, pd, 0, 2'd0, 4'd0, tk, ex);
  endtask

  // Monitor: the DUT presents a full output set after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (fsm_state !== e.st || start_timer !== e.start || value !== e.val ||
            siren !== e.sir || status_led !== e.led) begin
          failed++;
          $display("FAIL outputs @%0t: got st=%0d start=%0b val=%0d siren=%0b led=%0b, want st=%0d start=%0b val=%0d siren=%0b led=%0b",
                   $time, fsm_state, start_timer, value, siren, status_led,
                   e.st, e.start, e.val, e.sir, e.led);
        end
      end
    end
  end

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // driver trigger, stale expiry alongside start, sound, clear
    s(0, 1, 0, 0); s(0, 0, 0, 1); s(0, 0, 0, 1); s(0, 0, 0, 1);
    s(0, 0, 0, 0); s(0, 0, 0, 0); s(0, 0, 0, 1);
    // both doors together, then passenger only
    s(0, 1, 1, 0); s(1, 0, 0, 0); step(0, 0, 0, 0, 1, 2'd0, 4'd6, 0, 0);
    s(0, 0, 1, 0); s(0, 0, 0, 0); s(0, 0, 0, 0);
    // disarm path with door reopened during arm delay
    s(1, 0, 0, 0); s(0, 0, 0, 0); s(0, 1, 0, 0); s(0, 0, 0, 0);
    s(0, 0, 0, 0); s(0, 0, 1, 0); s(0, 0, 0, 0); s(0, 0, 0, 0);
    s(0, 0, 0, 0); s(0, 0, 0, 1);
    // sound restart with passenger open
    s(0, 1, 0, 0); s(0, 0, 0, 0); s(0, 0, 0, 0); s(0, 0, 0, 1);
    s(0, 0, 1, 0); s(0, 0, 1, 0); s(0, 0, 1, 1); s(0, 0, 1, 0);
    // reprogram during sound, then use new value
    step(0, 0, 0, 0, 1, 2'd1, 4'd3, 0, 0);
    s(0, 1, 0, 0); s(1, 0, 0, 0); step(0, 0, 0, 0, 1, 2'd0, 4'd6, 0, 0);
    s(0, 0, 1, 0); s(1, 0, 0, 0); step(0, 0, 0, 0, 1, 2'd0, 4'd6, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    s(0, 1, 0, 0); s(1, 0, 0, 0); step(0, 0, 0, 0, 1, 2'd0, 4'd6, 0, 0);
    // LED blink in ARMED
    for (int i = 0; i < 4; i++) begin s(0, 0, 0, 0, 1); s(0, 0, 0, 0, 0); end
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0));
    end
    s(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
